// File: rtl/logic_unit_arbiter_if.sv
// Requester handshake and shared logical unit bus
// for the two-port AND/OR arbiter.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             op0;
  logic             op1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic [WIDTH-1:0] lu_a;
  logic [WIDTH-1:0] lu_b;
  logic             lu_op;
  logic [WIDTH-1:0] lu_y;

  modport slave (
    input  req0,
    input  req1,
    input  a0,
    input  b0,
    input  a1,
    input  b1,
    input  op0,
    input  op1,
    input  lu_y,
    output gnt0,
    output gnt1,
    output done0,
    output done1,
    output result,
    output busy,
    output lu_a,
    output lu_b,
    output lu_op
  );

  modport master (
    output req0,
    output req1,
    output a0,
    output b0,
    output a1,
    output b1,
    output op0,
    output op1,
    output lu_y,
    input  gnt0,
    input  gnt1,
    input  done0,
    input  done1,
    input  result,
    input  busy,
    input  lu_a,
    input  lu_b,
    input  lu_op
  );

endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin two-requester front end that sequences
// one op at a time through the shared AND/OR unit.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  logic_unit_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             rr_q;
  logic             win_q;
  logic             win_d;
  logic             any_req;
  logic             accept;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [WIDTH-1:0] res_q;
  logic             in_exec;
  logic             in_done;

  assign any_req = bus.req0 | bus.req1;
  assign accept  = (state_q == IDLE) & any_req;
  assign in_exec = (state_q == EXEC);
  assign in_done = (state_q == DONE);

  // Winner: a lone requester always wins, contention goes to rr_q.
  always_comb begin
    win_d = 1'b0;
    unique case (1'b1)
      (bus.req0 & bus.req1):  win_d = rr_q;
      (bus.req1 & ~bus.req0): win_d = 1'b1;
      default:                win_d = 1'b0;
    endcase
  end

  // Next-state: IDLE -> EXEC on any request, then DONE, then IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = any_req ? EXEC : IDLE;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner's operands once, at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
    end else if (accept) begin
      win_q <= win_d;
      a_q   <= win_d ? bus.a1  : bus.a0;
      b_q   <= win_d ? bus.b1  : bus.b0;
      op_q  <= win_d ? bus.op1 : bus.op0;
    end
  end

  // Capture the shared unit output at the end of EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
    end else if (in_exec) begin
      res_q <= bus.lu_y;
    end
  end

  // Pointer moves to the port not just served on leaving DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= 1'b0;
    end else if (in_done) begin
      rr_q <= ~win_q;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.gnt0   = in_exec & ~win_q;
    bus.gnt1   = in_exec &  win_q;
    bus.done0  = in_done & ~win_q;
    bus.done1  = in_done &  win_q;
    bus.result = res_q;
    bus.lu_a   = in_exec ? a_q : '0;
    bus.lu_b   = in_exec ? b_q : '0;
    bus.lu_op  = in_exec & op_q;
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter:
// vector table, corner sequences, random vs model.
module tb_logic_unit_arbiter;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       op0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       op1;
    logic       w;
    logic [7:0] res;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic pref;

  logic_unit_arbiter_if #(.WIDTH(8)) bus ();

  logic_unit_arbiter #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.lu_y = bus.lu_op ? (bus.lu_a & bus.lu_b)
                              : (bus.lu_a | bus.lu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic r0, input logic r1,
    input logic [7:0] a0, input logic [7:0] b0,
    input logic op0,
    input logic [7:0] a1, input logic [7:0] b1,
    input logic op1,
    input logic w, input logic [7:0] res);
    vec_t v;
    v.r0 = r0; v.r1 = r1;
    v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.w = w; v.res = res;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = 8'h00; bus.b0 = 8'h00; bus.op0 = 1'b0;
    bus.a1 = 8'h00; bus.b1 = 8'h00; bus.op1 = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    pref = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"},
          {26'd0, bus.gnt0, bus.gnt1, bus.done0,
           bus.done1, bus.busy, bus.lu_op}, 32'd0);
    check({nm, "_res"}, {24'd0, bus.result}, 32'd0);
    check({nm, "_lua"}, {24'd0, bus.lu_a}, 32'd0);
    check({nm, "_lub"}, {24'd0, bus.lu_b}, 32'd0);
  endtask

  // Caller is 1 time unit after a posedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eo;
    bus.req0 = v.r0; bus.req1 = v.r1;
    bus.a0 = v.a0; bus.b0 = v.b0; bus.op0 = v.op0;
    bus.a1 = v.a1; bus.b1 = v.b1; bus.op1 = v.op1;
    if (!(v.r0 | v.r1)) begin
      tick();
      check({nm, "_idle"},
            {29'd0, bus.busy, bus.gnt0, bus.gnt1}, 32'd0);
      return;
    end
    ea = v.w ? v.a1 : v.a0;
    eb = v.w ? v.b1 : v.b0;
    eo = v.w ? v.op1 : v.op0;
    tick();
    check({nm, "_gnt"},
          {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1},
          {28'd0, ~v.w, v.w, 2'b00});
    check({nm, "_lu"},
          {7'd0, bus.busy, bus.lu_op, bus.lu_a, bus.lu_b},
          {7'd0, 1'b1, eo, ea, eb});
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = ~v.a0; bus.b0 = ~v.b0; bus.op0 = ~v.op0;
    bus.a1 = ~v.a1; bus.b1 = ~v.b1; bus.op1 = ~v.op1;
    tick();
    check({nm, "_done"},
          {27'd0, bus.busy, bus.gnt0, bus.gnt1,
           bus.done0, bus.done1},
          {27'd0, 1'b1, 2'b00, ~v.w, v.w});
    check({nm, "_res"}, {24'd0, bus.result}, {24'd0, v.res});
    check({nm, "_lu0"},
          {15'd0, bus.lu_op, bus.lu_a, bus.lu_b}, 32'd0);
    tick();
    check({nm, "_back"},
          {28'd0, bus.busy, bus.gnt0 | bus.gnt1,
           bus.done0, bus.done1}, 32'd0);
    check({nm, "_hold"}, {24'd0, bus.result}, {24'd0, v.res});
    pref = ~v.w;
  endtask

  vec_t tbl[10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pref     = 1'b0;
    reset_n  = 1'b0;
    idle_inputs();

    tbl[0] = mk(1'b1, 1'b0, 8'hA5, 8'h0F, 1'b0,
                8'h00, 8'h00, 1'b0, 1'b0, 8'hAF);
    tbl[1] = mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0,
                8'hA5, 8'h0F, 1'b1, 1'b1, 8'h05);
    tbl[2] = mk(1'b1, 1'b1, 8'hF0, 8'h0F, 1'b0,
                8'hF0, 8'h3C, 1'b1, 1'b0, 8'hFF);
    tbl[3] = mk(1'b1, 1'b1, 8'hF0, 8'h0F, 1'b0,
                8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30);
    tbl[4] = mk(1'b0, 1'b1, 8'h77, 8'h77, 1'b1,
                8'h3C, 8'hC3, 1'b0, 1'b1, 8'hFF);
    tbl[5] = mk(1'b1, 1'b1, 8'h12, 8'h36, 1'b1,
                8'h81, 8'h18, 1'b0, 1'b0, 8'h12);
    tbl[6] = mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0,
                8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00);
    tbl[7] = mk(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1,
                8'h55, 8'hAA, 1'b0, 1'b1, 8'hFF);
    tbl[8] = mk(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1,
                8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00);
    tbl[9] = mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1,
                8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

    // Reset held: toggling inputs must not disturb outputs.
    for (int i = 0; i < 4; i++) begin
      bus.req0 = $urandom_range(0, 1) == 1;
      bus.req1 = $urandom_range(0, 1) == 1;
      bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
      bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
      bus.op0 = $urandom_range(0, 1) == 1;
      bus.op1 = $urandom_range(0, 1) == 1;
      tick();
      check_zero("rst_hold");
    end
    idle_inputs();
    reset_n = 1'b1;
    tick();
    tick();
    check_zero("rst_rel");

    // Both ports held from reset: strict 0,1,0,1 at 3-cycle spacing.
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 8'hF0; bus.b0 = 8'h0F; bus.op0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 8'hF0; bus.b1 = 8'h3C; bus.op1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int  ph;
      logic w;
      tick();
      ph = c % 3;
      w  = ((c / 3) % 2) == 1;
      check("cont_gnt", {30'd0, bus.gnt0, bus.gnt1},
            {30'd0, (ph == 0) & ~w, (ph == 0) & w});
      check("cont_done", {30'd0, bus.done0, bus.done1},
            {30'd0, (ph == 1) & ~w, (ph == 1) & w});
      if (ph == 1) begin
        check("cont_res", {24'd0, bus.result},
              {24'd0, w ? 8'h30 : 8'hFF});
      end
    end
    idle_inputs();

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset in the grant cycle discards the op and the pointer.
    do_reset();
    run_vec(mk(1'b1, 1'b0, 8'h11, 8'h22, 1'b0,
               8'h00, 8'h00, 1'b0, 1'b0, 8'h33), "pre_rst");
    bus.req0 = 1'b1; bus.a0 = 8'h0F; bus.b0 = 8'hFF; bus.op0 = 1'b1;
    bus.req1 = 1'b1; bus.a1 = 8'h01; bus.b1 = 8'h02; bus.op1 = 1'b0;
    tick();
    check("mid_gnt1", {31'd0, bus.gnt1}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero("mid_rst");
    idle_inputs();
    tick();
    check("mid_nodone", {30'd0, bus.done0, bus.done1}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("mid_after",
          {29'd0, bus.busy, bus.done0, bus.done1}, 32'd0);
    pref = 1'b0;
    run_vec(mk(1'b1, 1'b1, 8'h0F, 8'hFF, 1'b1,
               8'h01, 8'h02, 1'b0, 1'b0, 8'h0F), "post_rst");

    // Random traffic against a round-robin preference model.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      logic eo;
      v.r0 = $urandom_range(0, 3) != 0;
      v.r1 = $urandom_range(0, 3) != 0;
      v.a0 = 8'($urandom); v.b0 = 8'($urandom);
      v.a1 = 8'($urandom); v.b1 = 8'($urandom);
      v.op0 = $urandom_range(0, 1) == 1;
      v.op1 = $urandom_range(0, 1) == 1;
      if (v.r0 && v.r1) v.w = pref;
      else              v.w = v.r1;
      eo = v.w ? v.op1 : v.op0;
      if (v.w) v.res = eo ? (v.a1 & v.b1) : (v.a1 | v.b1);
      else     v.res = eo ? (v.a0 & v.b0) : (v.a0 | v.b0);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
